dual_rail_tx: RTL and testbench
===============================

Name: dual_rail_tx

Overview:
- Clocked producer for the 4-phase return-to-zero dual-rail channels consumed by the asynchronous CORDIC datapath (shifters, completion-detected stages).
- Accepts single-rail operands through a valid/ready handshake and drives them as dual-rail codewords, each followed by an all-zero spacer.
- Sequences on the acknowledge returned by the downstream completion detector.
- Sits at the synchronous-to-asynchronous boundary feeding the square-root unit.

Parameters:
- SIZE, pa_AsyncCordic::RW, MSB index of the operand; the word is SIZE+1 bits.
- SYNC_STAGES, 2, flops in the ack_i synchronizer; minimum 2.
- TIMEOUT, 1024, cycles to wait for an ack edge before flagging err_o; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous, active-low reset.
- data_i  in  SIZE+1  single-rail operand.
- valid_i  in  1  operand valid.
- ready_o  out  1  transmitter can accept an operand.
- data_o  out  pa_AsyncCordic::dual_rail_t[SIZE:0]  dual-rail channel: data_1/data_0 per bit.
- ack_i  in  1  completion-detector acknowledge; asynchronous to clk.
- busy_o  out  1  a token is in flight (DATA or NULL state).
- err_o  out  1  sticky handshake-timeout flag.

Behaviour:
- All outputs are registered.
- data_o changes only on clk edges, and all bits are updated in the same edge.
- No bit of data_o may ever show data_1=data_0=1.
- Reset (arst low): data_o=all 0 (spacer), ready_o=0, busy_o=0, err_o=0, timeout counter=0, synchronizer=0, state=INIT. Reset is honoured mid-transfer: the spacer is driven immediately and any in-flight token is dropped.
- ack_s is ack_i after SYNC_STAGES flops. Only ack_s is used by the FSM.
- INIT: wait for ack_s=0, then go to IDLE with ready_o=1. This guarantees the downstream stage is empty after reset.
- IDLE:
  - ready_o=1, data_o=spacer.
  - On valid_i&ready_o, capture data_i.
  - Next edge: data_o[i].data_1=data_i[i] and data_o[i].data_0=~data_i[i] for all i. ready_o=0, busy_o=1, go to DATA.
  - data_i and valid_i are ignored while ready_o=0.
- DATA:
  - Hold the codeword until ack_s=1.
  - On that edge, data_o returns to all-zero spacer and the state goes to NULL.
- NULL:
  - Hold the spacer until ack_s=0.
  - Then go to IDLE with ready_o=1 and busy_o=0.
  - A new operand may be accepted in that same IDLE cycle.
- Minimum token period is 4 + 2*SYNC_STAGES cycles with zero downstream delay.
- Timeout:
  - The counter clears on every state change and increments each cycle in DATA or NULL.
  - When it reaches TIMEOUT (TIMEOUT>0), err_o is set and stays 1 until reset.
  - The FSM keeps waiting; the protocol is never aborted.
- ack_s=1 while in IDLE is a protocol violation: err_o is set and the state goes to INIT.
- A glitch shorter than SYNC_STAGES cycles on ack_i may be filtered. Downstream ack is level-held by protocol, so no requirement applies to such glitches.

Test Plan:
- Reset → data_o=0, ready_o=0. Hold ack_i=0 for SYNC_STAGES+1 cycles → ready_o=1, busy_o=0, err_o=0.
- SIZE=3, data_i=4'b1010 accepted:
  - Next cycle, data_o rails {b3..b0} data_1=1010, data_0=0101, busy_o=1.
  - Raise ack_i → spacer SYNC_STAGES+1 cycles later.
  - Drop ack_i → ready_o=1 SYNC_STAGES+1 cycles later.
- Back-to-back: valid_i held high with data 0x5 then 0xA and ack emulated by a 0-delay model → both codewords appear in order. Spacer between them, no cycle with both rails high, period 8 cycles at SYNC_STAGES=2.
- TIMEOUT=16, ack_i never rises after a send → err_o=1 exactly 16 cycles after entering DATA, codeword still held. A later ack_i completes normally with err_o still 1.
- Assert arst mid-DATA → data_o=0 and ready_o=0 asynchronously. After release with ack_i=1, the block stays in INIT until ack_i=0.
- ack_i forced high in IDLE → err_o=1, ready_o=0. Recovery occurs once ack_i=0.

Source files
------------

// File: rtl/pa_AsyncCordic.sv
// Shared types and widths for the asynchronous CORDIC datapath.
//   RW          : MSB index of a datapath word (word width is RW+1).
//   dual_rail_t : one dual-rail bit. {data_1,data_0} = 00 spacer, 10 logic 1,
//                 01 logic 0, 11 never legal.
package pa_AsyncCordic;

  localparam int RW = 15;

  typedef struct packed {
    logic data_1;
    logic data_0;
  } dual_rail_t;

endpackage

// File: rtl/dual_rail_tx.sv
// dual_rail_tx: clocked producer for a 4-phase return-to-zero dual-rail channel.
// Takes single-rail operands over valid/ready, and for each one drives a
// dual-rail codeword, then an all-zero spacer. It advances on the synchronized
// downstream acknowledge.
//
// Ports
//   clk      in   system clock
//   arst     in   asynchronous active-low reset
//   data_i   in   single-rail operand, SIZE+1 bits
//   valid_i  in   operand valid
//   ready_o  out  transmitter can accept an operand
//   data_o   out  dual-rail channel, one dual_rail_t per operand bit
//   ack_i    in   completion-detector acknowledge, asynchronous to clk
//   busy_o   out  token in flight (DATA or NULL)
//   err_o    out  sticky error: handshake timeout or ack seen while IDLE
//
// States
//   INIT | wait for the synchronizer to fill and for ack_s=0 (downstream empty)
//   IDLE | ready_o=1, spacer on the channel
//   LOAD | operand captured, codeword goes out on the next edge
//   DATA | codeword held until ack_s=1
//   NULL | spacer held until ack_s=0
module dual_rail_tx #(
  parameter int SIZE        = pa_AsyncCordic::RW,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic [SIZE:0]                      data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output pa_AsyncCordic::dual_rail_t [SIZE:0] data_o,
  input  logic                               ack_i,
  output logic                               busy_o,
  output logic                               err_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_DATA,
    ST_NULL
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  // prime_q fills with ones after reset. INIT must not trust ack_s until
  // ack_i has propagated through every synchronizer stage. Otherwise the
  // reset value of the synchronizer would look like a released ack.
  logic [SYNC_STAGES-1:0] prime_q, prime_d;
  logic                   ack_s;

  logic [SIZE:0]                       cap_q, cap_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic                                err_q, err_d;
  logic                                ready_q, ready_d;
  logic                                busy_q, busy_d;
  pa_AsyncCordic::dual_rail_t [SIZE:0] dout_q, dout_d;
  pa_AsyncCordic::dual_rail_t [SIZE:0] code;
  logic                                in_flight;

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i <= SIZE; i++) begin
      code[i].data_1 = cap_q[i];
      code[i].data_0 = ~cap_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack_i};
    prime_d    = {prime_q[SYNC_STAGES-2:0], 1'b1};

    unique case (state_q)
      ST_INIT: begin
        if (prime_q[SYNC_STAGES-1] && !ack_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // An ack while nothing is outstanding means the downstream is out of
        // step. Flag it and resynchronise through INIT.
        if (ack_s) begin
          err_d   = 1'b1;
          state_d = ST_INIT;
        end else if (valid_i && ready_q) begin
          cap_d   = data_i;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_DATA;
      ST_DATA: begin
        if (ack_s) state_d = ST_NULL;
      end
      ST_NULL: begin
        if (!ack_s) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    in_flight = (state_q == ST_DATA) || (state_q == ST_NULL);

    // The counter saturates at CNT_MAX, so a very late ack cannot wrap it.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_flight && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Timeout only raises err_o. The handshake continues and waits for the ack.
    if ((TIMEOUT > 0) && in_flight && (cnt_d == CNT_MAX)) err_d = 1'b1;

    // Outputs are decoded from the next state, so they are registered and
    // change together with the state.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_DATA) || (state_d == ST_NULL);
    dout_d  = (state_d == ST_DATA) ? code : '0;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= ST_INIT;
      ack_sync_q <= '0;
      prime_q    <= '0;
      cap_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      prime_q    <= prime_d;
      cap_q      <= cap_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;
  assign data_o  = dout_q;

endmodule

// File: tb/tb_dual_rail_tx.sv
// Self-checking bench for dual_rail_tx with SIZE=3, SYNC_STAGES=2, TIMEOUT=16.
// Channel encoding on the flattened 8-bit view: operand bit i sits at
// dout[2i+1:2i] = {data_1,data_0}. So 4'b1010 -> 8'h99 and 4'b0101 -> 8'h66.
module tb_dual_rail_tx;

  logic                                clk;
  logic                                arst;
  logic [3:0]                          data_i;
  logic                                valid_i;
  logic                                ready_o;
  pa_AsyncCordic::dual_rail_t [3:0]    data_o;
  logic                                ack_i;
  logic                                busy_o;
  logic                                err_o;

  logic [7:0] dout;
  logic       ack_drv;
  logic       model_en;
  logic       ack_model;

  int n_vec;
  int n_err;

  dual_rail_tx #(
    .SIZE       (3),
    .SYNC_STAGES(2),
    .TIMEOUT    (16)
  ) dut (
    .clk    (clk),
    .arst   (arst),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .ack_i  (ack_i),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dout = data_o;

  // Zero-delay completion detector: acknowledges as soon as every bit carries
  // a valid rail, and releases as soon as the channel returns to spacer.
  always_comb begin
    ack_model = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!(dout[2*i+1] | dout[2*i])) ack_model = 1'b0;
    end
  end

  assign ack_i = model_en ? ack_model : ack_drv;

  function automatic logic illegal_rails(input logic [7:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) r = r | (v[2*i+1] & v[2*i]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] d, input logic a);
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    ack_drv = a;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       a;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[8];

  int       acc;
  int       first_t;
  int       spacer_t;
  int       second_t;
  int       illegal;
  logic [7:0] first_v;
  logic [7:0] second_v;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    model_en = 1'b0;
    ack_drv  = 1'b0;
    valid_i  = 1'b0;
    data_i   = 4'h0;
    arst     = 1'b0;

    // One transfer of 4'b1010. Each row gives the inputs applied before an
    // edge and the outputs expected after it. In LOAD the operand is held
    // but not yet driven. Inputs offered while ready_o=0 must be ignored.
    tbl[0] = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};  // accept -> LOAD
    tbl[1] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99};  // DATA, codeword
    tbl[2] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h99};  // ack rises
    tbl[3] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h99};
    tbl[4] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};  // NULL, spacer
    tbl[5] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};  // ack falls
    tbl[6] = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};  // IDLE

    // Reset state
    #3;
    chk("rst_dout", {24'd0, dout}, 32'h00);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b1;

    // INIT -> IDLE after SYNC_STAGES+1 cycles with ack low
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    chk("init_ready_early", {31'd0, ready_o}, 32'd0);
    step(1'b0, 4'h0, 1'b0);
    chk("init_ready", {31'd0, ready_o}, 32'd1);
    chk("init_busy", {31'd0, busy_o}, 32'd0);
    chk("init_err", {31'd0, err_o}, 32'd0);

    // Table-driven single transfer
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].v, tbl[k].d, tbl[k].a);
      chk($sformatf("tbl%0d_ready", k), {31'd0, ready_o}, {31'd0, tbl[k].exp_ready});
      chk($sformatf("tbl%0d_busy", k), {31'd0, busy_o}, {31'd0, tbl[k].exp_busy});
      chk($sformatf("tbl%0d_err", k), {31'd0, err_o}, {31'd0, tbl[k].exp_err});
      chk($sformatf("tbl%0d_dout", k), {24'd0, dout}, {24'd0, tbl[k].exp_dout});
    end

    // Back-to-back with the zero-delay ack model: 0x5 then 0xA
    model_en = 1'b1;
    acc      = 0;
    first_t  = -1;
    spacer_t = -1;
    second_t = -1;
    illegal  = 0;
    first_v  = 8'h00;
    second_v = 8'h00;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (acc < 2) begin
        valid_i = 1'b1;
        data_i  = (acc == 0) ? 4'h5 : 4'hA;
        if (ready_o) acc++;
      end else begin
        valid_i = 1'b0;
      end
      @(posedge clk);
      #1;
      if (illegal_rails(dout)) illegal++;
      if (first_t < 0 && dout != 8'h00) begin
        first_t = c;
        first_v = dout;
      end else if (first_t >= 0 && spacer_t < 0 && dout == 8'h00) begin
        spacer_t = c;
      end else if (spacer_t >= 0 && second_t < 0 && dout != 8'h00) begin
        second_t = c;
        second_v = dout;
      end
    end
    model_en = 1'b0;
    ack_drv  = 1'b0;
    chk("b2b_first_code", {24'd0, first_v}, 32'h66);
    chk("b2b_second_code", {24'd0, second_v}, 32'h99);
    chk("b2b_period", second_t - first_t, 32'd8);
    chk("b2b_hold", spacer_t - first_t, 32'd3);
    chk("b2b_illegal", illegal, 32'd0);
    chk("b2b_end_ready", {31'd0, ready_o}, 32'd1);

    // Timeout: ack never arrives
    step(1'b1, 4'hA, 1'b0);                   // LOAD
    step(1'b0, 4'h0, 1'b0);                   // enter DATA
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 4'h0, 1'b0);
      if (k == 15) chk("to_err_early", {31'd0, err_o}, 32'd0);
    end
    chk("to_err", {31'd0, err_o}, 32'd1);
    chk("to_dout_held", {24'd0, dout}, 32'h99);
    chk("to_busy", {31'd0, busy_o}, 32'd1);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    chk("to_late_hold", {24'd0, dout}, 32'h99);
    step(1'b0, 4'h0, 1'b1);
    chk("to_late_spacer", {24'd0, dout}, 32'h00);
    chk("to_late_err", {31'd0, err_o}, 32'd1);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    chk("to_done_ready", {31'd0, ready_o}, 32'd1);
    chk("to_done_busy", {31'd0, busy_o}, 32'd0);
    chk("to_done_err", {31'd0, err_o}, 32'd1);

    // Reset in the middle of DATA, then release with ack high
    step(1'b1, 4'h5, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    chk("mid_dout_code", {24'd0, dout}, 32'h66);
    ack_drv = 1'b1;
    #2;
    arst = 1'b0;
    #1;
    chk("mid_rst_dout", {24'd0, dout}, 32'h00);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b1, 4'hF, 1'b1);
    chk("mid_init_hold", {31'd0, ready_o}, 32'd0);
    chk("mid_init_err", {31'd0, err_o}, 32'd0);
    chk("mid_init_dout", {24'd0, dout}, 32'h00);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    chk("mid_rel_early", {31'd0, ready_o}, 32'd0);
    step(1'b0, 4'h0, 1'b0);
    chk("mid_rel_ready", {31'd0, ready_o}, 32'd1);

    // ack high while IDLE is a protocol violation
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    chk("viol_early_ready", {31'd0, ready_o}, 32'd1);
    chk("viol_early_err", {31'd0, err_o}, 32'd0);
    step(1'b0, 4'h0, 1'b1);
    chk("viol_ready", {31'd0, ready_o}, 32'd0);
    chk("viol_err", {31'd0, err_o}, 32'd1);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 1'b0);
    chk("viol_recover_ready", {31'd0, ready_o}, 32'd1);
    chk("viol_recover_err", {31'd0, err_o}, 32'd1);
    chk("viol_recover_dout", {24'd0, dout}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
